// File: rtl/key_sw_io_dev_pkg.sv
// Shared definitions for the KEY/SW input device: bus addresses,
// register offsets, CTRL bit positions and the CTRL word packer.
package key_sw_io_dev_pkg;

    localparam logic [31:0] ADDRKEY  = 32'hFFFFF080;
    localparam logic [31:0] ADDRSW   = 32'hFFFFF090;
    localparam logic [31:0] DATA_OFF = 32'd0;
    localparam logic [31:0] CTRL_OFF = 32'd4;

    localparam int READY_BIT   = 0;
    localparam int OVERRUN_BIT = 2;
    localparam int IE_BIT      = 8;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_KDATA,
        REG_KCTRL,
        REG_SDATA,
        REG_SCTRL
    } reg_sel_e;

    function automatic logic [IE_BIT:0] ctrl_word(
        input logic rdy,
        input logic ovr,
        input logic ie
    );
        logic [IE_BIT:0] w;
        w              = '0;
        w[READY_BIT]   = rdy;
        w[OVERRUN_BIT] = ovr;
        w[IE_BIT]      = ie;
        return w;
    endfunction

endpackage

// File: rtl/key_sw_io_dev_if.sv
// MEM-stage load/store port between the CPU (master) and an
// I/O responder (slave).
interface key_sw_io_dev_if #(
    parameter int DBITS = 32
);
    logic [DBITS-1:0] addr;
    logic             rd_en;
    logic             wr_en;
    logic [DBITS-1:0] wr_data;
    logic             hit;
    logic [DBITS-1:0] rd_data;

    modport master (
        output addr,
        output rd_en,
        output wr_en,
        output wr_data,
        input  hit,
        input  rd_data
    );

    modport slave (
        input  addr,
        input  rd_en,
        input  wr_en,
        input  wr_data,
        output hit,
        output rd_data
    );
endinterface

// File: rtl/key_sw_io_dev_io_status_reg.sv
// Data register plus sticky ready/overrun flags and interrupt enable.
// ie is only built when KEY_SW_IRQ_EN is defined.
module io_status_reg #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_commit,
    input  logic [W-1:0] i_new_value,
    input  logic         i_data_read,
    input  logic         i_ctrl_write,
    input  logic         i_ovf_wbit,
    input  logic         i_ie_wbit,
    output logic [W-1:0] o_data,
    output logic         o_ready,
    output logic         o_overrun,
    output logic         o_ie
);

    logic [W-1:0] r_data;
    logic         r_ready;
    logic         r_overrun;
    logic         w_ovf_set;
    logic         w_ovf_clr;

    // A read landing on the same edge as a commit consumes the old
    // value, so the new one is not an overrun.
    assign w_ovf_set = i_commit & r_ready & ~i_data_read;
    assign w_ovf_clr = i_ctrl_write & ~i_ovf_wbit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data    <= '0;
            r_ready   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (i_commit) begin
                r_data <= i_new_value;
            end
            if (i_commit) begin
                r_ready <= 1'b1;
            end else if (i_data_read) begin
                r_ready <= 1'b0;
            end
            if (w_ovf_set) begin
                r_overrun <= 1'b1;
            end else if (w_ovf_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

`ifdef KEY_SW_IRQ_EN
    logic r_ie;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ie <= 1'b0;
        end else if (i_ctrl_write) begin
            r_ie <= i_ie_wbit;
        end
    end

    assign o_ie = r_ie;
`else
    logic w_unused_ie;
    assign w_unused_ie = i_ie_wbit;
    assign o_ie        = 1'b0;
`endif

    assign o_data    = r_data;
    assign o_ready   = r_ready;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/key_sw_io_dev.sv
// KEY/SW memory-mapped input device: pin sync, SW debounce, register
// decode and interrupt. Optional interrupts under KEY_SW_IRQ_EN.
module key_sw_io_dev
    import key_sw_io_dev_pkg::*;
#(
    parameter int               DBITS           = 32,
    parameter int               KEYBITS         = 4,
    parameter int               SWBITS          = 10,
    parameter logic [DBITS-1:0] ADDRKEY         =
        DBITS'(key_sw_io_dev_pkg::ADDRKEY),
    parameter logic [DBITS-1:0] ADDRSW          =
        DBITS'(key_sw_io_dev_pkg::ADDRSW),
    parameter int               DEBOUNCE_CYCLES = 500000,
    parameter int               CNTBITS         = 20
) (
    input  logic               clk,
    input  logic               reset,
    key_sw_io_dev_if.slave     bus,
    input  logic [KEYBITS-1:0] key_n,
    input  logic [SWBITS-1:0]  sw,
    output logic               intr
);

    localparam logic [DBITS-1:0] A_KDATA = ADDRKEY + DBITS'(DATA_OFF);
    localparam logic [DBITS-1:0] A_KCTRL = ADDRKEY + DBITS'(CTRL_OFF);
    localparam logic [DBITS-1:0] A_SDATA = ADDRSW + DBITS'(DATA_OFF);
    localparam logic [DBITS-1:0] A_SCTRL = ADDRSW + DBITS'(CTRL_OFF);
    localparam logic [CNTBITS-1:0] CNT_MAX =
        CNTBITS'(DEBOUNCE_CYCLES - 1);

    logic [KEYBITS-1:0] r_key_s1;
    logic [KEYBITS-1:0] r_key_s2;
    logic [SWBITS-1:0]  r_sw_s1;
    logic [SWBITS-1:0]  r_sw_s2;
    logic [SWBITS-1:0]  r_sw_cand;
    logic [CNTBITS-1:0] r_cnt;

    logic [DBITS-3:0]   w_word;
    reg_sel_e           w_sel;

    logic [KEYBITS-1:0] w_kdata;
    logic               w_krdy;
    logic               w_kovr;
    logic               w_kie;
    logic [SWBITS-1:0]  w_sdata;
    logic               w_srdy;
    logic               w_sovr;
    logic               w_sie;

    logic               w_key_commit;
    logic               w_sw_stable;
    logic               w_cnt_full;
    logic               w_sw_commit;
    logic               w_kdata_rd;
    logic               w_sdata_rd;
    logic               w_kctrl_wr;
    logic               w_sctrl_wr;
    logic               w_unused;

    // KEY is inverted so that a pressed key reads as 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_key_s1 <= '0;
            r_key_s2 <= '0;
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
        end else begin
            r_key_s1 <= ~key_n;
            r_key_s2 <= r_key_s1;
            r_sw_s1  <= sw;
            r_sw_s2  <= r_sw_s1;
        end
    end

    assign w_sw_stable = (r_sw_s2 == r_sw_cand);
    assign w_cnt_full  = (r_cnt == CNT_MAX);

    // Any movement restarts the window; the count holds once full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sw_cand <= '0;
            r_cnt     <= '0;
        end else if (!w_sw_stable) begin
            r_sw_cand <= r_sw_s2;
            r_cnt     <= '0;
        end else if (!w_cnt_full) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_key_commit = (r_key_s2 != w_kdata);
    assign w_sw_commit  = w_sw_stable & w_cnt_full &
                          (r_sw_cand != w_sdata);

    assign w_word = bus.addr[DBITS-1:2];

    always_comb begin
        w_sel = REG_NONE;
        unique case (1'b1)
            (w_word == A_KDATA[DBITS-1:2]): w_sel = REG_KDATA;
            (w_word == A_KCTRL[DBITS-1:2]): w_sel = REG_KCTRL;
            (w_word == A_SDATA[DBITS-1:2]): w_sel = REG_SDATA;
            (w_word == A_SCTRL[DBITS-1:2]): w_sel = REG_SCTRL;
            default:                        w_sel = REG_NONE;
        endcase
    end

    assign w_kdata_rd = bus.rd_en & (w_sel == REG_KDATA);
    assign w_sdata_rd = bus.rd_en & (w_sel == REG_SDATA);
    assign w_kctrl_wr = bus.wr_en & (w_sel == REG_KCTRL);
    assign w_sctrl_wr = bus.wr_en & (w_sel == REG_SCTRL);

    assign bus.hit = (w_sel != REG_NONE);

    always_comb begin
        bus.rd_data = '0;
        case (w_sel)
            REG_KDATA: bus.rd_data = DBITS'(w_kdata);
            REG_KCTRL: bus.rd_data =
                DBITS'(ctrl_word(w_krdy, w_kovr, w_kie));
            REG_SDATA: bus.rd_data = DBITS'(w_sdata);
            REG_SCTRL: bus.rd_data =
                DBITS'(ctrl_word(w_srdy, w_sovr, w_sie));
            default:   bus.rd_data = '0;
        endcase
    end

    io_status_reg #(
        .W (KEYBITS)
    ) u_key (
        .clk          (clk),
        .reset        (reset),
        .i_commit     (w_key_commit),
        .i_new_value  (r_key_s2),
        .i_data_read  (w_kdata_rd),
        .i_ctrl_write (w_kctrl_wr),
        .i_ovf_wbit   (bus.wr_data[OVERRUN_BIT]),
        .i_ie_wbit    (bus.wr_data[IE_BIT]),
        .o_data       (w_kdata),
        .o_ready      (w_krdy),
        .o_overrun    (w_kovr),
        .o_ie         (w_kie)
    );

    io_status_reg #(
        .W (SWBITS)
    ) u_sw (
        .clk          (clk),
        .reset        (reset),
        .i_commit     (w_sw_commit),
        .i_new_value  (r_sw_cand),
        .i_data_read  (w_sdata_rd),
        .i_ctrl_write (w_sctrl_wr),
        .i_ovf_wbit   (bus.wr_data[OVERRUN_BIT]),
        .i_ie_wbit    (bus.wr_data[IE_BIT]),
        .o_data       (w_sdata),
        .o_ready      (w_srdy),
        .o_overrun    (w_sovr),
        .o_ie         (w_sie)
    );

`ifdef KEY_SW_IRQ_EN
    logic r_intr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_intr <= 1'b0;
        end else begin
            r_intr <= (w_krdy & w_kie) | (w_srdy & w_sie);
        end
    end

    assign intr = r_intr;
`else
    assign intr = 1'b0;
`endif

    assign w_unused = &{1'b0, bus.addr[1:0], bus.wr_data};

endmodule
